// File: rtl/proc_out_fifo_mmio.sv
// Output FIFO sink for the pixel processor with a small CPU register window.
// The processor pushes pixels over valid/ready. The CPU drains them through
// the DATA register, monitors progress through STATUS, and flushes the FIFO
// or clears the frame-done flag through CTRL.
module proc_out_fifo_mmio #(
    parameter int          DEPTH      = 16,
    parameter int          IMAGE_SIZE = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0200_1010
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    output logic        in_ready,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(IMAGE_SIZE + 1);

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [FW-1:0] frame_cnt;
    logic          frame_done;

    logic          empty;
    logic          full;
    logic [31:0]   offset;
    logic          hit_data;
    logic          hit_status;
    logic          hit_ctrl;
    logic          sel;
    logic          hs;
    logic          is_write;
    logic          push;
    logic          accept;
    logic          pop;
    logic          flush;
    logic          clr_done;
    logic          frame_last;
    logic          unused_wdata;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));

    // Only the three word addresses of the window decode; anything else is
    // left unanswered so the bus master sees no ready.
    assign offset     = mem_addr - BASE_ADDR;
    assign hit_data   = (offset == 32'h0);
    assign hit_status = (offset == 32'h4);
    assign hit_ctrl   = (offset == 32'h8);
    assign sel        = mem_valid & (hit_data | hit_status | hit_ctrl);
    assign hs         = sel & mem_ready;
    assign is_write   = |mem_wstrb;

    assign push       = in_valid & ~full;
    // A push landing on the flush cycle is dropped and not counted toward the frame.
    assign flush      = hs & hit_ctrl & is_write & mem_wdata[0];
    assign clr_done   = hs & hit_ctrl & is_write & mem_wdata[1];
    assign accept     = push & ~flush;
    assign pop        = hs & hit_data & ~is_write & ~empty;
    assign frame_last = (frame_cnt == FW'(IMAGE_SIZE - 1));

    assign in_ready     = ~full;
    assign irq          = frame_done;
    assign unused_wdata = ^mem_wdata[31:2];

    // Bus ready: one-cycle pulse per select, then a mandatory idle cycle.
    always_ff @(posedge clk) begin
        if (!resetn) mem_ready <= 1'b0;
        else         mem_ready <= sel & ~mem_ready;
    end

    // Pixel storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= in_pixel;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Frame accounting; setting frame_done takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (flush) begin
                frame_cnt <= '0;
            end else if (accept) begin
                frame_cnt <= frame_last ? '0 : frame_cnt + FW'(1);
            end
            if (accept && frame_last) frame_done <= 1'b1;
            else if (clr_done)        frame_done <= 1'b0;
        end
    end

    // Read mux: live view of current state while selected, zero otherwise.
    always_comb begin
        mem_rdata = '0;
        if (sel) begin
            if (hit_data && !empty) begin
                mem_rdata = {23'b0, 1'b1, fifo_mem[rd_ptr]};
            end else if (hit_status) begin
                mem_rdata = {16'(level), 13'b0, frame_done, full, empty};
            end
        end
    end

endmodule

// File: tb/tb_proc_out_fifo_mmio.sv
// Scoreboard bench for proc_out_fifo_mmio: pixels are queued as the model
// accepts them and popped when DATA reads return.
module tb_proc_out_fifo_mmio;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0200_1010;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [7:0]  in_pixel;
    logic        in_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        irq;

    int          n_cmp;
    int          n_err;
    int          model_lvl;
    logic [7:0]  sb[$];

    proc_out_fifo_mmio dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic push_one(input logic [7:0] p);
        in_valid = 1'b1;
        in_pixel = p;
        @(negedge clk);
        check_eq("in_ready", 32'(in_ready), 32'(model_lvl < DEPTH));
        @(posedge clk);
        if (model_lvl < DEPTH) begin
            sb.push_back(p);
            model_lvl++;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        bit done;
        done      = 1'b0;
        rdata     = '0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = wdata;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                rdata = mem_rdata;
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        if (!done) check_eq("bus_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_data();
        logic [31:0] rd;
        logic [31:0] exp;
        bus(A_DATA, 4'h0, 32'h0, rd);
        if (model_lvl > 0) begin
            exp = {23'b0, 1'b1, sb.pop_front()};
            model_lvl--;
        end else begin
            exp = 32'h0;
        end
        check_eq("data", rd, exp);
    endtask

    task automatic read_status(input logic [31:0] exp);
        logic [31:0] rd;
        bus(A_STAT, 4'h0, 32'h0, rd);
        check_eq("status", rd, exp);
    endtask

    task automatic write_ctrl(input logic [31:0] v);
        logic [31:0] rd;
        bus(A_CTRL, 4'hF, v, rd);
        if (v[0]) begin
            sb.delete();
            model_lvl = 0;
        end
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            push_one(8'(i * 7 + 3));
            read_data();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; model_lvl = 0;
        resetn = 1'b0; in_valid = 1'b0; in_pixel = '0;
        mem_valid = 1'b0; mem_wstrb = '0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_mem_ready", 32'(mem_ready), 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'd0);

        // Fill to full, then drain in order.
        for (int i = 1; i <= 16; i++) push_one(8'(i));
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        read_status(32'h0010_0002);
        for (int i = 0; i < 16; i++) read_data();
        read_status(32'h0000_0001);
        check_eq("drained_in_ready", 32'(in_ready), 32'd1);

        // Read while empty.
        read_data();
        read_status(32'h0000_0001);

        // Unmapped address must not answer.
        mem_valid = 1'b1; mem_addr = BASE + 32'hC; mem_wstrb = 4'h0;
        repeat (3) begin
            @(negedge clk);
            check_eq("unmapped_ready", 32'(mem_ready), 32'd0);
            check_eq("unmapped_rdata", mem_rdata, 32'd0);
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;

        // Full with a waiting pixel: one pop lets exactly one push in.
        for (int i = 0; i < 16; i++) push_one(8'(8'h20 + i));
        in_valid = 1'b1;
        in_pixel = 8'h30;
        read_data();
        check_eq("slot_freed", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(8'h30);
        model_lvl++;
        check_eq("refull", 32'(in_ready), 32'd0);
        read_status(32'h0010_0002);
        for (int i = 0; i < 16; i++) read_data();
        read_status(32'h0000_0001);

        // Frame detection from a fresh count.
        write_ctrl(32'h1);
        stream(1023);
        check_eq("irq_1023", 32'(irq), 32'd0);
        stream(1);
        check_eq("irq_1024", 32'(irq), 32'd1);
        read_status(32'h0000_0005);
        write_ctrl(32'h2);
        check_eq("irq_cleared", 32'(irq), 32'd0);

        // Flush with a push in flight; frame count must restart.
        for (int i = 0; i < 5; i++) push_one(8'(8'h50 + i));
        in_valid = 1'b1;
        in_pixel = 8'h77;
        write_ctrl(32'h1);
        in_valid = 1'b0;
        read_status(32'h0000_0001);
        stream(1023);
        check_eq("irq_after_flush_1023", 32'(irq), 32'd0);
        stream(1);
        check_eq("irq_after_flush_1024", 32'(irq), 32'd1);

        // Flush alone leaves frame_done untouched.
        write_ctrl(32'h1);
        check_eq("flush_keeps_irq", 32'(irq), 32'd1);

        // Reset in the middle of a DATA read with 7 entries buffered.
        for (int i = 0; i < 7; i++) push_one(8'(8'h90 + i));
        mem_valid = 1'b1; mem_addr = A_DATA; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        check_eq("mid_ready", 32'(mem_ready), 32'd1);
        check_eq("mid_rdata", mem_rdata, 32'h0000_0190);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_mem_ready", 32'(mem_ready), 32'd0);
        check_eq("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_mid_irq", 32'(irq), 32'd0);
        check_eq("rst_mid_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        resetn = 1'b1;
        sb.delete();
        model_lvl = 0;
        read_status(32'h0000_0001);
        read_data();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
